// File: rtl/pipe_xfer.sv
// pipe_xfer: one-cycle valid/ready pipeline stage carrying LANES x WIDTH payloads,
// with global stall, synchronous flush and a saturating empty-cycle counter.
// Build option PIPE_XFER_SKID_EN: adds a skid entry so in_ready is taken from a
// flop and has no combinational path from out_ready. Without it the stage holds
// a single entry and in_ready follows out_ready combinationally.
module pipe_xfer #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      LANES     = 5,
  parameter int unsigned      NOP_LANE  = 4,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(32'h00000013)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [15:0]            bubble_cnt
);

  localparam int unsigned DW = LANES * WIDTH;
  localparam int unsigned CW = 16;

  // Empty-stage payload: NOP in lane NOP_LANE, zero everywhere else.
  localparam logic [DW-1:0] BUBBLE = DW'(NOP_VALUE) << (NOP_LANE * WIDTH);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] bubble_cnt_q, bubble_cnt_d;

  logic          active;
  logic          in_hs;
  logic          out_hs;

  // Handshake qualification shared by both buffer structures.
  always_comb begin
    active = !stall && !flush;
    out_hs = valid_q && out_ready && active;
    in_hs  = in_valid && in_ready;
  end

`ifdef PIPE_XFER_SKID_EN

  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_data_q, skid_data_d;

  // Accept whenever the skid slot is free; the only flop-free terms are the global controls.
  assign in_ready = active && !reset && !skid_valid_q;

  // Main/skid next state: refill main from skid first so order is preserved.
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      valid_d      = 1'b0;
      data_d       = BUBBLE;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end else if (!stall) begin
      if (!valid_q || out_hs) begin
        if (skid_valid_q) begin
          valid_d      = 1'b1;
          data_d       = skid_data_q;
          skid_valid_d = 1'b0;
        end else if (in_hs) begin
          valid_d = 1'b1;
          data_d  = in_data;
        end else begin
          valid_d = 1'b0;
          data_d  = BUBBLE;
        end
      end else if (in_hs) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end
  end

  // Skid entry registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

`else

  // Single entry: accept when empty or when the held entry leaves this cycle.
  assign in_ready = active && !reset && (!valid_q || out_ready);

  // Main entry next state: load beats drain, drain leaves the bubble payload.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = BUBBLE;
    end else if (!stall) begin
      if (in_hs) begin
        valid_d = 1'b1;
        data_d  = in_data;
      end else if (out_hs) begin
        valid_d = 1'b0;
        data_d  = BUBBLE;
      end
    end
  end

`endif

  // Count edges where downstream was ready but nothing was presented; saturates.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (out_ready && !valid_q && active && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CW'(1);
    end
  end

  // Main entry and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      data_q       <= BUBBLE;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: doc/pipe_xfer.md
PIPE_XFER -- requirements
Module: pipe_xfer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the bit width of one lane.
REQ-002 The block SHALL have parameter LANES, default 5, giving the number of lanes carried per transfer.
REQ-003 The block SHALL have parameter NOP_LANE, default 4, giving the lane index loaded with NOP_VALUE on reset and flush.
REQ-004 The block SHALL have parameter NOP_VALUE, default 32'h00000013, the bubble value for lane NOP_LANE.
REQ-005 The block SHALL have the following ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  global freeze; no state changes while high.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream holds a transfer.
- in_ready  output  1  block accepts a transfer this cycle.
- in_data  input  LANES*WIDTH  upstream payload; lane k is bits [k*WIDTH +: WIDTH].
- out_valid  output  1  block presents a transfer.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  LANES*WIDTH  presented payload.
- bubble_cnt  output  16  saturating count of empty cycles.

Function
REQ-006 A handshake SHALL occur on an input or output port only when its valid and ready are both high on a rising edge, with stall low and flush low.
REQ-007 Payload SHALL pass through unmodified, with latency of one cycle from input handshake to out_valid high.
REQ-008 When no entry is held, out_data SHALL show NOP_VALUE in lane NOP_LANE and zero in all other lanes.
REQ-009 While stall is high, every register SHALL hold its value and in_ready SHALL be low; out_valid and out_data SHALL stay stable.
REQ-010 While flush is high, in_ready SHALL be low; at the next edge all entries SHALL be dropped (out_valid goes low, out_data goes to the bubble value).
REQ-011 Flush SHALL take priority over stall.
REQ-012 An input offered during a flush cycle SHALL NOT be accepted.
REQ-013 Output handshake and input handshake in the same cycle SHALL replace the entry without a bubble, sustaining one transfer per cycle.
REQ-014 Occupancy full: in_ready SHALL be low, and the held entry SHALL stay unchanged until an output handshake.
REQ-015 bubble_cnt SHALL increment by 1 on each edge where out_ready=1, out_valid=0, stall=0 and flush=0.
REQ-016 bubble_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-017 bubble_cnt SHALL be unaffected by flush.
REQ-018 in_valid SHALL NOT be required to remain asserted before acceptance; out_valid, once high, SHALL remain high with stable out_data until an output handshake or flush.

Reset
REQ-019 On reset assertion, regardless of clk, the block SHALL immediately drive: out_valid=0, out_data=bubble value, bubble_cnt=0, all entries empty.
REQ-020 While reset is high, in_ready SHALL be 0.
REQ-021 Reset asserted mid-transfer SHALL discard all held data; no held data SHALL appear after release.
REQ-022 The first handshake SHALL be possible on the first rising edge after reset deassertion.

Configuration
REQ-023 The macro PIPE_XFER_SKID_EN SHALL select the buffer structure.
REQ-024 With PIPE_XFER_SKID_EN undefined, the block SHALL hold one entry, and in_ready SHALL equal !stall && !flush && !reset && (!out_valid || out_ready), a combinational path from out_ready.
REQ-025 With PIPE_XFER_SKID_EN defined, the block SHALL hold two entries (main plus skid), and in_ready SHALL be a registered output (no combinational path from out_ready), high when the skid entry is empty.
REQ-026 In skid mode, output order SHALL be preserved.
REQ-027 In skid mode, latency SHALL remain one cycle.
REQ-028 In skid mode, flush SHALL empty both entries.

Verification
REQ-029 The bench SHALL cover back-to-back transfers: in_valid=1 and out_ready=1 for 10 cycles, lane0 = 1..10 -> out_valid high from cycle 2, lane0 = 1..10 in order, no gaps.
REQ-030 The bench SHALL cover stall mid-stream: stall=1 for 3 cycles while out_valid=1, lane0=5 -> out_data constant, in_ready=0, and the stream resumes with 6 after stall drops.
REQ-031 The bench SHALL cover flush with stall: flush=1 and stall=1 together while holding lane0=7 -> next cycle out_valid=0, lane 4 = 32'h00000013, other lanes 0, and the offered input is not accepted.
REQ-032 The bench SHALL cover backpressure: out_ready=0 for 4 cycles with in_valid=1 -> exactly 1 (no skid) or 2 (PIPE_XFER_SKID_EN) transfers accepted, none lost or duplicated after out_ready=1.
REQ-033 The bench SHALL cover asynchronous reset: reset pulsed between clock edges while out_valid=1 -> outputs go to reset values before the next edge, and bubble_cnt=0.
REQ-034 The bench SHALL cover counter saturation: out_ready=1, in_valid=0 for 70000 cycles -> bubble_cnt=16'hFFFF and holds.
